timing_decode_unit: RTL and testbench

//  Upstream stage of the DR control-signal logic. Generates the one-hot timing vector T

---
 rtl/timing_decode_unit_if.sv | 37 +++
 rtl/timing_decode_unit.sv | 75 +++++++
 tb/tb_timing_decode_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/timing_decode_unit_if.sv
// Control/status bundle between the instruction control logic and timing_decode_unit.
// Optional sc_wrap_err member present only when SC_WRAP_ERR_EN is defined.
interface timing_decode_unit_if #(
   parameter int SC_W  = 3,
   parameter int OPC_W = 3
);
   logic                  start;
   logic                  halt;
   logic                  sc_clr;
   logic                  dec_en;
   logic [OPC_W-1:0]      ir_opc;
   logic                  ir_i;
   logic [(2**SC_W)-1:0]  T;
   logic [(2**OPC_W)-1:0] D;
   logic                  I;
   logic                  S;
   logic [SC_W-1:0]       sc;
`ifdef SC_WRAP_ERR_EN
   logic                  sc_wrap_err;
`endif

   modport master (
      output start, halt, sc_clr, dec_en, ir_opc, ir_i,
`ifdef SC_WRAP_ERR_EN
      input  sc_wrap_err,
`endif
      input  T, D, I, S, sc
   );

   modport slave (
      input  start, halt, sc_clr, dec_en, ir_opc, ir_i,
`ifdef SC_WRAP_ERR_EN
      output sc_wrap_err,
`endif
      output T, D, I, S, sc
   );
endinterface

// File: rtl/timing_decode_unit.sv
// Timing/opcode decoder: run flag S, sequence counter, one-hot T and registered one-hot D/I.
// Define SC_WRAP_ERR_EN to add the sticky sc_wrap_err flag for an unclr'd counter wrap.
module timing_decode_unit #(
   parameter int SC_W  = 3,
   parameter int OPC_W = 3
) (
   input logic                  clk,
   input logic                  rst,
   timing_decode_unit_if.slave  bus
);
   localparam int T_W   = 2**SC_W;
   localparam int D_W   = 2**OPC_W;
   localparam logic [SC_W-1:0] SC_MAX = '1;

   logic             s_q,   s_nxt;
   logic [SC_W-1:0]  sc_q,  sc_nxt;
   logic [D_W-1:0]   d_q,   d_nxt;
   logic             i_q,   i_nxt;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      s_nxt  = s_q;
      sc_nxt = '0;
      d_nxt  = d_q;
      i_nxt  = i_q;

      if (bus.halt)
         s_nxt = 1'b0;
      else if (bus.start)
         s_nxt = 1'b1;

      // Counter only advances while running; halt and sc_clr both restart the instruction.
      if (s_q && !bus.halt && !bus.sc_clr)
         sc_nxt = sc_q + 1'b1;

      if (s_q && bus.dec_en) begin
         d_nxt = D_W'(1) << bus.ir_opc;
         i_nxt = bus.ir_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q  <= 1'b0;
         sc_q <= '0;
         d_q  <= '0;
         i_q  <= 1'b0;
      end else begin
         s_q  <= s_nxt;
         sc_q <= sc_nxt;
         d_q  <= d_nxt;
         i_q  <= i_nxt;
      end
   end

`ifdef SC_WRAP_ERR_EN
   logic wrap_err_q;

   always_ff @(posedge clk) begin
      if (rst)
         wrap_err_q <= 1'b0;
      else if (s_q && (sc_q == SC_MAX) && !bus.sc_clr && !bus.halt)
         wrap_err_q <= 1'b1;
   end

   assign bus.sc_wrap_err = wrap_err_q;
`endif

   assign bus.T  = s_q ? (T_W'(1) << sc_q) : '0;
   assign bus.D  = d_q;
   assign bus.I  = i_q;
   assign bus.S  = s_q;
   assign bus.sc = sc_q;
endmodule

// File: tb/tb_timing_decode_unit.sv
// Self-checking bench for timing_decode_unit: directed scenarios plus randomized stimulus
// compared against an integer-level model of the run flag, step count and decoded opcode.
module tb_timing_decode_unit;
   localparam int SC_W  = 3;
   localparam int OPC_W = 3;
   localparam int STEPS = 2**SC_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // Reference model: run flag, step index within instruction, last decoded opcode (-1 = none).
   bit m_run;
   int m_step;
   int m_opc;
   bit m_i;
   bit m_err;

   timing_decode_unit_if #(.SC_W(SC_W), .OPC_W(OPC_W)) bus ();

   timing_decode_unit #(.SC_W(SC_W), .OPC_W(OPC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [STEPS-1:0] exp_t();
      return m_run ? (STEPS)'(2**m_step) : '0;
   endfunction

   function automatic logic [(2**OPC_W)-1:0] exp_d();
      return (m_opc < 0) ? '0 : (2**OPC_W)'(2**m_opc);
   endfunction

   // Drive one cycle of inputs, advance the model with the same rules, sample 1 time unit later.
   task automatic tick(input bit r, input bit st, input bit h, input bit clr,
                       input bit de, input int opc, input bit ii);
      bit was_run;
      rst        = r;
      bus.start  = st;
      bus.halt   = h;
      bus.sc_clr = clr;
      bus.dec_en = de;
      bus.ir_opc = OPC_W'(opc);
      bus.ir_i   = ii;
      @(posedge clk);
      if (r) begin
         m_run = 0; m_step = 0; m_opc = -1; m_i = 0; m_err = 0;
      end else begin
         was_run = m_run;
         if (was_run && de) begin
            m_opc = opc;
            m_i   = ii;
         end
         if (was_run && !h && !clr && m_step == STEPS-1) m_err = 1;
         if (was_run && !h && !clr) m_step = (m_step + 1) % STEPS;
         else m_step = 0;
         if (h) m_run = 0;
         else if (st) m_run = 1;
      end
      #1;
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      tick(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(7)), 1'($urandom));
      total++;
      if (bus.T !== 8'h00 || bus.D !== 8'h00 || bus.I !== 1'b0 || bus.S !== 1'b0 || bus.sc !== 3'd0) begin
         bad++;
         $display("FAIL reset: T=%h D=%h I=%b S=%b sc=%0d want all zero", bus.T, bus.D, bus.I, bus.S, bus.sc);
      end
   endtask

   task automatic test_timing_chain();
      logic [7:0] seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      tick(0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) idle();
         total++;
         if (bus.T !== seq[k] || bus.S !== 1'b1) begin
            bad++;
            $display("FAIL chain[%0d]: T=%h S=%b want T=%h S=1", k, bus.T, bus.S, seq[k]);
         end
      end
   endtask

   task automatic test_decode();
      tick(0, 0, 0, 1, 0, 0, 0);   // T -> 01
      idle();                      // 02
      idle();                      // 04
      tick(0, 0, 0, 0, 1, 6, 1);   // dec_en at T=04
      total++;
      if (bus.D !== 8'h40 || bus.I !== 1'b1 || bus.T !== 8'h08) begin
         bad++;
         $display("FAIL decode: D=%h I=%b T=%h want D=40 I=1 T=08", bus.D, bus.I, bus.T);
      end
      for (int k = 0; k < 2; k++) begin
         tick(0, 0, 0, 0, 0, int'($urandom_range(7)), 1'($urandom));
         total++;
         if (bus.D !== 8'h40 || bus.I !== 1'b1 || bus.T !== (8'h10 << k)) begin
            bad++;
            $display("FAIL decode_hold[%0d]: D=%h I=%b T=%h want D=40 I=1 T=%h", k, bus.D, bus.I, bus.T, 8'h10 << k);
         end
      end
   endtask

   task automatic test_sc_clr();
      tick(0, 0, 0, 1, 0, 0, 0);   // clr while T=20
      total++;
      if (bus.T !== 8'h01 || bus.D !== 8'h40 || bus.sc !== 3'd0) begin
         bad++;
         $display("FAIL sc_clr: T=%h D=%h sc=%0d want T=01 D=40 sc=0", bus.T, bus.D, bus.sc);
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 7; k++) idle();
      total++;
      if (bus.T !== 8'h80) begin
         bad++;
         $display("FAIL wrap_pre: T=%h want 80", bus.T);
      end
`ifdef SC_WRAP_ERR_EN
      total++;
      if (bus.sc_wrap_err !== 1'b0) begin
         bad++;
         $display("FAIL wrap_err_pre: got %b want 0", bus.sc_wrap_err);
      end
`endif
      idle();
      total++;
      if (bus.T !== 8'h01 || bus.sc !== 3'd0) begin
         bad++;
         $display("FAIL wrap: T=%h sc=%0d want T=01 sc=0", bus.T, bus.sc);
      end
`ifdef SC_WRAP_ERR_EN
      tick(0, 0, 0, 1, 0, 0, 0);
      idle();
      total++;
      if (bus.sc_wrap_err !== 1'b1) begin
         bad++;
         $display("FAIL wrap_err_sticky: got %b want 1", bus.sc_wrap_err);
      end
`endif
   endtask

   task automatic test_halt();
      tick(0, 0, 1, 1, 0, 0, 0);   // halt + sc_clr
      total++;
      if (bus.T !== 8'h00 || bus.S !== 1'b0 || bus.sc !== 3'd0 || bus.D !== 8'h40 || bus.I !== 1'b1) begin
         bad++;
         $display("FAIL halt_clr: T=%h S=%b sc=%0d D=%h I=%b want 00 0 0 40 1", bus.T, bus.S, bus.sc, bus.D, bus.I);
      end
      tick(0, 0, 0, 0, 1, 2, 0);   // dec_en while stopped is ignored
      total++;
      if (bus.D !== 8'h40 || bus.I !== 1'b1 || bus.T !== 8'h00) begin
         bad++;
         $display("FAIL dec_stopped: D=%h I=%b T=%h want D=40 I=1 T=00", bus.D, bus.I, bus.T);
      end
      tick(0, 1, 0, 0, 0, 0, 0);
      tick(0, 1, 1, 0, 0, 0, 0);   // halt beats start
      total++;
      if (bus.S !== 1'b0 || bus.T !== 8'h00) begin
         bad++;
         $display("FAIL halt_start: S=%b T=%h want S=0 T=00", bus.S, bus.T);
      end
      tick(0, 1, 0, 0, 0, 0, 0);
      idle();
      tick(0, 1, 0, 0, 0, 0, 0);   // start while running has no effect
      idle();
      total++;
      if (bus.T !== 8'h08) begin
         bad++;
         $display("FAIL pre_rst: T=%h want 08", bus.T);
      end
      tick(1, 0, 0, 0, 0, 0, 0);
      total++;
      if (bus.T !== 8'h00 || bus.D !== 8'h00 || bus.I !== 1'b0 || bus.S !== 1'b0 || bus.sc !== 3'd0) begin
         bad++;
         $display("FAIL mid_rst: T=%h D=%h I=%b S=%b sc=%0d want all zero", bus.T, bus.D, bus.I, bus.S, bus.sc);
      end
`ifdef SC_WRAP_ERR_EN
      total++;
      if (bus.sc_wrap_err !== 1'b0) begin
         bad++;
         $display("FAIL wrap_err_rst: got %b want 0", bus.sc_wrap_err);
      end
`endif
      idle();
      total++;
      if (bus.S !== 1'b0 || bus.T !== 8'h00) begin
         bad++;
         $display("FAIL no_restart: S=%b T=%h want S=0 T=00", bus.S, bus.T);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int n = 0; n < 400; n++) begin
         tick($urandom_range(99) < 2, $urandom_range(99) < 12, $urandom_range(99) < 5,
              $urandom_range(99) < 15, $urandom_range(99) < 30,
              int'($urandom_range(2**OPC_W - 1)), 1'($urandom));
         total++;
         if (bus.T !== exp_t() || bus.D !== exp_d() || bus.I !== m_i ||
             bus.S !== m_run || bus.sc !== SC_W'(m_step)
`ifdef SC_WRAP_ERR_EN
             || bus.sc_wrap_err !== m_err
`endif
            ) begin
            bad++;
            if (errs++ < 10)
               $display("FAIL random[%0d]: T=%h D=%h I=%b S=%b sc=%0d want T=%h D=%h I=%b S=%b sc=%0d",
                        n, bus.T, bus.D, bus.I, bus.S, bus.sc, exp_t(), exp_d(), m_i, m_run, m_step);
         end
      end
   endtask

   initial begin
      m_run = 0; m_step = 0; m_opc = -1; m_i = 0; m_err = 0;
      bus.start = 0; bus.halt = 0; bus.sc_clr = 0; bus.dec_en = 0; bus.ir_opc = '0; bus.ir_i = 0;
      @(negedge clk);
      test_reset();
      test_timing_chain();
      test_decode();
      test_sc_clr();
      test_wrap();
      test_halt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
